// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types for the decoupled instruction prefetch unit.
// Holds the queue entry layout and fetch-related constants.
package fetch_prefetch_unit_pkg;

    localparam int FETCH_XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

    function automatic logic [FETCH_XLEN-1:0] word_align(
        input logic [FETCH_XLEN-1:0] a
    );
        return a & ~FETCH_XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Ports: clk, reset (sync, active-high), flush_i, push_i/wdata_i,
// pop_i/rdata_o, empty_o, full_o, count_o.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DEPTH_L);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full queue still accepts a write when the head leaves this cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Decoupled instruction prefetch between imem and the IF/ID register.
// Ports: clk, reset; imem_req_* (valid/ready/addr) out to imem;
// imem_rsp_* (valid/data) in-order responses; redirect_valid/redirect_pc;
// fetch_valid/fetch_ready/fetch_pc/fetch_instr to decode;
// if_id_flush/id_ex_flush mirror redirect_valid.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic [31:0]     fetch_instr,
    output logic            if_id_flush,
    output logic            id_ex_flush
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(FIFO_DEPTH);
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            issue_ok;
    logic            req_fire;
    logic            rsp_keep;
    logic            deq;

    fetch_entry_t    pq_wr;
    fetch_entry_t    pq_head;
    logic [EW-1:0]   pq_rdata;
    logic            pq_empty;
    logic [CW-1:0]   pq_count;
    logic [XLEN-1:0] if_head;

    logic            unused_pq_full;
    logic            unused_if_empty;
    logic            unused_if_full;
    logic [CW-1:0]   unused_if_count;

    assign if_id_flush = redirect_valid;
    assign id_ex_flush = redirect_valid;

    // Credit rule: every issued request already owns a queue slot.
    assign issue_ok = !redirect_valid
                   && (drop_q == '0)
                   && (out_q < MAX_L)
                   && (({1'b0, out_q} + {1'b0, pq_count}) < DEPTH_L);

    assign imem_req_valid = !reset && issue_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses during a redirect or while draining stale requests are dropped.
    assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

    assign pq_head     = fetch_entry_t'(pq_rdata);
    assign fetch_valid = !reset && !pq_empty;
    assign fetch_pc    = fetch_valid ? XLEN'(pq_head.pc) : '0;
    assign fetch_instr = fetch_valid ? pq_head.instr : '0;
    assign deq         = fetch_valid && fetch_ready && !redirect_valid;

    assign pq_wr.pc    = FETCH_XLEN'(if_head);
    assign pq_wr.instr = imem_rsp_data;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch_q (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (rsp_keep),
        .wdata_i (pq_wr),
        .pop_i   (deq),
        .rdata_o (pq_rdata),
        .empty_o (pq_empty),
        .full_o  (unused_pq_full),
        .count_o (pq_count)
    );

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_inflight_q (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (rsp_keep),
        .rdata_o (if_head),
        .empty_o (unused_if_empty),
        .full_o  (unused_if_full),
        .count_o (unused_if_count)
    );

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        out_d  = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~XLEN'(3);
            // Everything still in flight after this cycle is stale.
            drop_d = out_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(4);
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed scoreboard bench for fetch_prefetch_unit.
// A 1-cycle in-order imem model feeds an expected-entry queue.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        if_id_flush;
    logic        id_ex_flush;

    fetch_prefetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst_r = 1'b1;
    logic        rdy_r = 1'b0;
    logic        frdy_r = 1'b0;
    logic        redir_r = 1'b0;
    logic [31:0] redir_pc_r = '0;
    logic        hold_r = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    int          epoch = 0;
    logic [31:0] exp_addr = '0;

    logic        obs_rv, obs_fv, obs_ifl, obs_idl;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_1357;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at negedge, observe 1 time unit later,
    // then account for handshakes that complete at the next posedge.
    task automatic tick();
        pend_t       p;
        logic [63:0] e;
        @(negedge clk);
        reset          = rst_r;
        imem_req_ready = rdy_r;
        fetch_ready    = frdy_r;
        redirect_valid = redir_r;
        redirect_pc    = redir_pc_r;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst_r) begin
            pend.delete();
            exp_q.delete();
            epoch++;
            exp_addr = '0;
        end else if (!hold_r && pend.size() != 0) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(p.addr);
            if (p.epoch == epoch && !redir_r)
                exp_q.push_back({p.addr, instr_of(p.addr)});
        end
        #1;
        obs_rv    = imem_req_valid;
        obs_fv    = fetch_valid;
        obs_ifl   = if_id_flush;
        obs_idl   = id_ex_flush;
        obs_addr  = imem_req_addr;
        obs_pc    = fetch_pc;
        obs_instr = fetch_instr;
        chk("if_id_flush", 32'(if_id_flush), 32'(redir_r));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(redir_r));
        if (redir_r) chk("redir_no_req", 32'(imem_req_valid), 0);
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_addr);
            pend.push_back('{addr: imem_req_addr, epoch: epoch});
            exp_addr = exp_addr + 32'd4;
        end
        if (fetch_valid && fetch_ready && !redirect_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed pc=%h expected=none",
                       fetch_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("fetch_pc", fetch_pc, e[63:32]);
                chk("fetch_instr", fetch_instr, e[31:0]);
            end
        end
        if (redir_r && !rst_r) begin
            exp_q.delete();
            epoch++;
            exp_addr = redir_pc_r & ~32'h3;
        end
    endtask

    int          first;
    int          nvalid;
    int          npop;
    int          n;
    int          found;
    logic [31:0] pcs [4];

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fetch_ready    = 1'b0;

        rst_r = 1'b1;
        repeat (3) tick();
        chk("rst_req_valid", 32'(obs_rv), 0);
        chk("rst_fetch_valid", 32'(obs_fv), 0);
        chk("rst_fetch_pc", obs_pc, 0);
        chk("rst_fetch_instr", obs_instr, 0);

        rst_r  = 1'b0;
        rdy_r  = 1'b1;
        frdy_r = 1'b1;
        first  = -1;
        nvalid = 0;
        npop   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_fv) begin
                if (first < 0) first = i;
                nvalid++;
                if (npop < 4) pcs[npop] = obs_pc;
                npop++;
            end
        end
        chk("stream_first_idx", first, 2);
        chk("stream_no_gaps", nvalid, 10 - first);
        chk("stream_pc0", pcs[0], 32'h0);
        chk("stream_pc1", pcs[1], 32'h4);
        chk("stream_pc2", pcs[2], 32'h8);
        chk("stream_pc3", pcs[3], 32'hC);

        frdy_r = 1'b0;
        repeat (10) tick();
        chk("bp_req_valid", 32'(obs_rv), 0);
        chk("bp_fetch_valid", 32'(obs_fv), 1);
        rdy_r  = 1'b0;
        frdy_r = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (obs_fv) n++;
        end
        chk("bp_buffered", n, 4);

        rdy_r  = 1'b1;
        hold_r = 1'b1;
        repeat (4) tick();
        chk("hold_req_valid", 32'(obs_rv), 0);
        redir_r    = 1'b1;
        redir_pc_r = 32'h100;
        tick();
        chk("redir_if_id_flush", 32'(obs_ifl), 1);
        chk("redir_id_ex_flush", 32'(obs_idl), 1);
        redir_r = 1'b0;
        hold_r  = 1'b0;
        tick();
        chk("drop_flush_clear", 32'(obs_ifl), 0);
        chk("drop_req_valid0", 32'(obs_rv), 0);
        tick();
        chk("drop_req_valid1", 32'(obs_rv), 0);
        tick();
        chk("redir_req_valid", 32'(obs_rv), 1);
        chk("redir_req_addr", obs_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            tick();
            if (obs_fv) begin
                found = 1;
                chk("redir_fetch_pc", obs_pc, 32'h100);
            end
        end
        chk("redir_fetch_seen", found, 1);

        repeat (4) tick();
        redir_r    = 1'b1;
        redir_pc_r = 32'h300;
        tick();
        chk("rr_fetch_valid", 32'(obs_fv), 1);
        redir_r = 1'b0;
        tick();
        chk("rr_req_valid", 32'(obs_rv), 1);
        chk("rr_req_addr", obs_addr, 32'h300);
        repeat (4) tick();

        redir_r    = 1'b1;
        redir_pc_r = 32'hFFFF_FFFC;
        tick();
        redir_r = 1'b0;
        tick();
        chk("wrap_req_addr_hi", obs_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_req_valid", 32'(obs_rv), 1);
        chk("wrap_req_addr_0", obs_addr, 32'h0);
        repeat (4) tick();

        redir_r    = 1'b1;
        redir_pc_r = 32'h203;
        tick();
        redir_r = 1'b0;
        tick();
        chk("align_req_addr", obs_addr, 32'h200);
        repeat (4) tick();

        rst_r = 1'b1;
        tick();
        tick();
        chk("mid_rst_fetch_valid", 32'(obs_fv), 0);
        chk("mid_rst_req_valid", 32'(obs_rv), 0);
        chk("mid_rst_fetch_pc", obs_pc, 0);
        rst_r = 1'b0;
        tick();
        chk("post_rst_req_valid", 32'(obs_rv), 1);
        chk("post_rst_req_addr", obs_addr, 32'h0);
        chk("post_rst_fetch_valid", 32'(obs_fv), 0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
